// File: rtl/lm70_frame_capture_if.sv
// LM70 capture bus: SPI pins in, captured frame and display byte out.
// Optional t_min/t_max appear only when LM70_MINMAX_EN is defined.
interface lm70_frame_capture_if;
   logic              cs_n;
   logic              sck;
   logic              sio;
   logic              sel_lsb;
   logic [15:0]       raw;
   logic signed [8:0] temp_c;
   logic [7:0]        disp_byte;
   logic              frame_valid;
   logic              frame_err;
`ifdef LM70_MINMAX_EN
   logic signed [8:0] t_min;
   logic signed [8:0] t_max;
`endif

   modport master (
      output cs_n, sck, sio, sel_lsb,
      input  raw, temp_c, disp_byte, frame_valid, frame_err
`ifdef LM70_MINMAX_EN
      , input t_min, t_max
`endif
   );

   modport slave (
      input  cs_n, sck, sio, sel_lsb,
      output raw, temp_c, disp_byte, frame_valid, frame_err
`ifdef LM70_MINMAX_EN
      , output t_min, t_max
`endif
   );
endinterface

// File: rtl/lm70_frame_capture.sv
// LM70 SPI frame capture: shifts a 16-bit frame, reports whole-degree C.
// Define LM70_MINMAX_EN to add running t_min/t_max registers.
module lm70_frame_capture #(
   parameter int FRAME_BITS   = 16,
   parameter int IDLE_TIMEOUT = 64
) (
   input logic                 clk,
   input logic                 rst_n,
   lm70_frame_capture_if.slave bus
);
   localparam int BW = $clog2(FRAME_BITS + 2);
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_DONE, S_ERR, S_WAIT
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic           r_cs_q;
   logic           r_sck_q;
   logic [15:0]    r_shreg;
   logic [BW-1:0]  r_bitcnt;
   logic [TW-1:0]  r_tocnt;
   logic [15:0]    r_raw;
   logic           r_valid;
   logic           r_err;

   logic w_sck_rise, w_cs_fall, w_cs_rise;
   logic w_tmo, w_good;
   logic w_clr, w_shift, w_tick, w_load, w_fail;

   assign w_sck_rise = !r_sck_q && bus.sck;
   assign w_cs_fall  = r_cs_q && !bus.cs_n;
   assign w_cs_rise  = !r_cs_q && bus.cs_n;
   assign w_tmo      = r_tocnt == TW'(IDLE_TIMEOUT);
   assign w_good     = r_bitcnt == BW'(FRAME_BITS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_cs_fall) w_next = S_SHIFT;
         S_SHIFT: begin
            if (w_cs_rise)  w_next = S_DONE;
            else if (w_tmo) w_next = S_ERR;
         end
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_WAIT;
         S_WAIT:  if (bus.cs_n) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_clr   = 1'b0;
      w_shift = 1'b0;
      w_tick  = 1'b0;
      w_load  = 1'b0;
      w_fail  = 1'b0;
      unique case (r_state)
         S_IDLE:  w_clr = w_cs_fall;
         S_SHIFT: begin
            // a CS rise wins over an SCK rise in the same cycle
            if (!w_cs_rise && !w_tmo) begin
               w_shift = w_sck_rise;
               w_tick  = !w_sck_rise;
            end
         end
         S_DONE: begin
            w_load = w_good;
            w_fail = !w_good;
         end
         S_ERR:   w_fail = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_q   <= 1'b0;
         r_sck_q  <= 1'b0;
         r_shreg  <= '0;
         r_bitcnt <= '0;
         r_tocnt  <= '0;
         r_raw    <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_cs_q  <= bus.cs_n;
         r_sck_q <= bus.sck;
         r_valid <= w_load;
         r_err   <= w_fail;
         if (w_clr) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_tocnt  <= '0;
         end
         if (w_shift) begin
            r_shreg <= {r_shreg[14:0], bus.sio};
            r_tocnt <= '0;
            if (r_bitcnt != BW'(FRAME_BITS + 1))
               r_bitcnt <= r_bitcnt + 1'b1;
         end
         if (w_tick) r_tocnt <= r_tocnt + 1'b1;
         if (w_load) r_raw <= r_shreg;
      end
   end

   assign bus.raw         = r_raw;
   assign bus.temp_c      = r_raw[15:7];
   assign bus.disp_byte   = bus.sel_lsb ? r_raw[7:0] : r_raw[15:8];
   assign bus.frame_valid = r_valid;
   assign bus.frame_err   = r_err;

`ifdef LM70_MINMAX_EN
   logic signed [8:0] r_t_min;
   logic signed [8:0] r_t_max;
   logic signed [8:0] w_t_new;

   assign w_t_new = r_shreg[15:7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t_min <= 9'sh0FF;
         r_t_max <= 9'sh100;
      end else if (w_load) begin
         if (w_t_new < r_t_min) r_t_min <= w_t_new;
         if (w_t_new > r_t_max) r_t_max <= w_t_new;
      end
   end

   assign bus.t_min = r_t_min;
   assign bus.t_max = r_t_max;
`endif
endmodule

// File: tb/tb_lm70_frame_capture.sv
// Randomized self-checking bench for lm70_frame_capture.
// Reference model: frame value, whole-degree floor, min/max kept in plain ints.
module tb_lm70_frame_capture;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] exp_raw;
   int          exp_min, exp_max;

   lm70_frame_capture_if bus ();

   lm70_frame_capture #(
      .FRAME_BITS   (16),
      .IDLE_TIMEOUT (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int floor_c(input logic [15:0] r);
      int v;
      v = int'($signed(r));
      if (v >= 0) return v / 128;
      return -((-v + 127) / 128);
   endfunction

   function automatic void model_frame(input logic [15:0] d, input int nb);
      if (nb == 16) begin
         exp_raw = d;
         if (floor_c(d) < exp_min) exp_min = floor_c(d);
         if (floor_c(d) > exp_max) exp_max = floor_c(d);
      end
   endfunction

   // Sequencer-like driver; SCK and SIO change on the clk negedge.
   task automatic drive_frame(input logic [15:0] d, input int nb,
                              input bit collide, output int vcnt,
                              output int vpos, output int ecnt,
                              output int epos);
      @(negedge clk) bus.cs_n = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int i = nb - 1; i >= 0; i--) begin
         @(negedge clk);
         bus.sck = 1'b1;
         bus.sio = (i < 16) ? d[i] : 1'($urandom);
         @(negedge clk) bus.sck = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      bus.cs_n = 1'b1;
      if (collide) begin
         bus.sck = 1'b1;
         bus.sio = 1'($urandom);
      end
      vcnt = 0; vpos = 0; ecnt = 0; epos = 0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         if (bus.frame_valid) begin vcnt++; vpos = k; end
         if (bus.frame_err)   begin ecnt++; epos = k; end
      end
      @(negedge clk) bus.sck = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_raw = '0;
      exp_min = 255;
      exp_max = -256;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.raw !== 16'h0) begin
         errors++; $display("FAIL reset_raw got %h want 0000", bus.raw);
      end
      checks++;
      if (bus.temp_c !== 9'h0) begin
         errors++; $display("FAIL reset_temp got %h want 000", bus.temp_c);
      end
      checks++;
      if (bus.disp_byte !== 8'h0) begin
         errors++; $display("FAIL reset_disp got %h want 00", bus.disp_byte);
      end
      checks++;
      if (bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses got v=%b e=%b want 0 0",
                  bus.frame_valid, bus.frame_err);
      end
   endtask

   task automatic test_good_frame(input logic [15:0] d, input bit col);
      int vc, vp, ec, ep;
      drive_frame(d, 16, col, vc, vp, ec, ep);
      model_frame(d, 16);
      checks++;
      if (vc !== 1 || vp !== 2 || ec !== 0) begin
         errors++;
         $display("FAIL good_pulse got v=%0d@%0d e=%0d want 1@2 0",
                  vc, vp, ec);
      end
      checks++;
      if (bus.raw !== exp_raw) begin
         errors++; $display("FAIL good_raw got %h want %h", bus.raw, exp_raw);
      end
      checks++;
      if (int'(bus.temp_c) !== floor_c(exp_raw)) begin
         errors++;
         $display("FAIL good_temp got %0d want %0d",
                  bus.temp_c, floor_c(exp_raw));
      end
   endtask

   task automatic test_negative();
      test_good_frame(16'hF380, 1'b0);
      checks++;
      if (int'(bus.temp_c) !== -25) begin
         errors++; $display("FAIL neg_temp got %0d want -25", bus.temp_c);
      end
      bus.sel_lsb = 1'b1;
      #1;
      checks++;
      if (bus.disp_byte !== 8'h80) begin
         errors++; $display("FAIL disp_lsb got %h want 80", bus.disp_byte);
      end
      bus.sel_lsb = 1'b0;
      #1;
      checks++;
      if (bus.disp_byte !== 8'hF3) begin
         errors++; $display("FAIL disp_msb got %h want f3", bus.disp_byte);
      end
   endtask

   task automatic test_bad_frame(input int nb);
      int vc, vp, ec, ep;
      logic [15:0] prev;
      prev = exp_raw;
      drive_frame(16'($urandom), nb, 1'b0, vc, vp, ec, ep);
      checks++;
      if (vc !== 0 || ec !== 1 || ep !== 2) begin
         errors++;
         $display("FAIL bad_%0d got v=%0d e=%0d@%0d want 0 1@2",
                  nb, vc, ec, ep);
      end
      checks++;
      if (bus.raw !== prev) begin
         errors++;
         $display("FAIL bad_%0d_raw got %h want %h", nb, bus.raw, prev);
      end
   endtask

   task automatic test_timeout();
      int ec, at, vc;
      ec = 0; at = 0; vc = 0;
      @(negedge clk) bus.cs_n = 1'b0;
      for (int k = 1; k <= 90; k++) begin
         @(posedge clk);
         #1;
         if (bus.frame_err) begin ec++; at = k; end
         if (bus.frame_valid) vc++;
      end
      checks++;
      if (ec !== 1 || at < 64 || at > 68) begin
         errors++;
         $display("FAIL timeout got %0d pulses at %0d want 1 in 64..68",
                  ec, at);
      end
      @(negedge clk) bus.cs_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (bus.frame_err) ec++;
         if (bus.frame_valid) vc++;
      end
      checks++;
      if (ec !== 1 || vc !== 0) begin
         errors++;
         $display("FAIL timeout_after got e=%0d v=%0d want 1 0", ec, vc);
      end
   endtask

   task automatic test_reset_midframe();
      int pc;
      logic [15:0] d;
      d = 16'($urandom);
      pc = 0;
      @(negedge clk) bus.cs_n = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); bus.sck = 1'b1; bus.sio = d[15 - i];
         @(negedge clk); bus.sck = 1'b0;
      end
      do_reset();
      #1;
      checks++;
      if (bus.raw !== 16'h0 || bus.frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset got raw=%h v=%b want 0000 0",
                  bus.raw, bus.frame_valid);
      end
      for (int i = 9; i < 16; i++) begin
         @(negedge clk); bus.sck = 1'b1; bus.sio = d[15 - i];
         @(negedge clk); bus.sck = 1'b0;
      end
      @(negedge clk) bus.cs_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         if (bus.frame_valid || bus.frame_err) pc++;
      end
      checks++;
      if (pc !== 0) begin
         errors++; $display("FAIL stale_cs got %0d pulses want 0", pc);
      end
      test_good_frame(16'h4B00, 1'b0);
      checks++;
      if (int'(bus.temp_c) !== 150) begin
         errors++; $display("FAIL temp150 got %0d want 150", bus.temp_c);
      end
   endtask

   task automatic test_random();
      int vc, vp, ec, ep, nb, sel;
      logic [15:0] d;
      bit col;
      for (int n = 0; n < 24; n++) begin
         d = 16'($urandom);
         sel = int'($urandom_range(0, 9));
         nb = (sel == 0) ? 8 : (sel == 1) ? 15 : (sel == 2) ? 17 : 16;
         col = 1'($urandom);
         drive_frame(d, nb, col, vc, vp, ec, ep);
         model_frame(d, nb);
         checks++;
         if ((nb == 16 && (vc !== 1 || vp !== 2 || ec !== 0)) ||
             (nb != 16 && (vc !== 0 || ec !== 1 || ep !== 2))) begin
            errors++;
            $display("FAIL rnd_pulse n=%0d bits=%0d got v=%0d e=%0d",
                     n, nb, vc, ec);
         end
         checks++;
         if (bus.raw !== exp_raw ||
             int'(bus.temp_c) !== floor_c(exp_raw)) begin
            errors++;
            $display("FAIL rnd_raw got %h/%0d want %h/%0d", bus.raw,
                     bus.temp_c, exp_raw, floor_c(exp_raw));
         end
         bus.sel_lsb = 1'($urandom);
         #1;
         checks++;
         if (bus.disp_byte !==
             (bus.sel_lsb ? exp_raw[7:0] : exp_raw[15:8])) begin
            errors++;
            $display("FAIL rnd_disp got %h raw %h sel %b",
                     bus.disp_byte, exp_raw, bus.sel_lsb);
         end
`ifdef LM70_MINMAX_EN
         checks++;
         if (int'(bus.t_min) !== exp_min || int'(bus.t_max) !== exp_max) begin
            errors++;
            $display("FAIL rnd_minmax got %0d/%0d want %0d/%0d",
                     bus.t_min, bus.t_max, exp_min, exp_max);
         end
`endif
      end
   endtask

`ifdef LM70_MINMAX_EN
   task automatic test_minmax();
      do_reset();
      #1;
      checks++;
      if (bus.t_min !== 9'h0FF || bus.t_max !== 9'h100) begin
         errors++;
         $display("FAIL minmax_reset got %h/%h want 0ff/100",
                  bus.t_min, bus.t_max);
      end
      test_good_frame(16'h0C80, 1'b0);
      test_good_frame(16'hFB00, 1'b0);
      test_good_frame(16'h4B00, 1'b0);
      checks++;
      if (int'(bus.t_min) !== -10 || int'(bus.t_max) !== 150) begin
         errors++;
         $display("FAIL minmax got %0d/%0d want -10/150",
                  bus.t_min, bus.t_max);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      bus.cs_n = 1'b1;
      bus.sck = 1'b0;
      bus.sio = 1'b0;
      bus.sel_lsb = 1'b0;
      exp_raw = '0;
      exp_min = 255;
      exp_max = -256;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      test_reset();
      test_good_frame(16'h0C80, 1'b0);
      checks++;
      if (int'(bus.temp_c) !== 25) begin
         errors++; $display("FAIL temp25 got %0d want 25", bus.temp_c);
      end
      test_negative();
      test_bad_frame(8);
      test_bad_frame(17);
      test_good_frame(16'h1234, 1'b1);
      test_timeout();
      test_good_frame(16'hFFE0, 1'b0);
      test_reset_midframe();
      test_random();
`ifdef LM70_MINMAX_EN
      test_minmax();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lm70_frame_capture.md
# lm70_frame_capture

Receives the LM70 serial temperature frame on the SPI bus driven by the SPI sequencer (CS/SCK generator) and assembles it into a parallel word. Converts the frame to signed whole-degree Celsius and presents it to the 7-segment display path with a one-cycle valid strobe. Sits directly downstream of the sequencer. Consumes CS, SCK and SIO in the `clk` domain and feeds `uo_out` formatting.

## Interface
Parameters:
- `FRAME_BITS`, 16: SCK rising edges that make a complete frame.
- `IDLE_TIMEOUT`, 64: `clk` cycles with CS low and no SCK edge before the frame is aborted.

Ports:
- `clk`  in  1  system clock. The sequencer's SCK toggles on the `clk` negedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs_n`  in  1  LM70 chip select from the sequencer, active low.
- `sck`  in  1  SPI clock from the sequencer.
- `sio`  in  1  LM70 serial data (`uio_in[2]`).
- `sel_lsb`  in  1  display byte select: 1 = `raw[7:0]`, 0 = `raw[15:8]`.
- `raw`  out  16  last good frame, MSB first.
- `temp_c`  out  9  signed integer °C, equal to `raw[15:7]`.
- `disp_byte`  out  8  byte chosen by `sel_lsb` from `raw`.
- `frame_valid`  out  1  one-cycle pulse when a good frame is latched.
- `frame_err`  out  1  one-cycle pulse on a short, long or timed-out frame.
- `t_min`, `t_max`  out  9  signed running extremes. Present only with `LM70_MINMAX_EN`.

## Operation
- All inputs are sampled on `clk` posedge. Registered copies are `cs_q` and `sck_q`.
- SCK rise is `sck_q==0 && sck==1`. CS fall is `cs_q==1 && cs_n==0`. CS rise is `cs_q==0 && cs_n==1`.
- FSM states and transitions:
  - IDLE → SHIFT on CS fall. Clears `shreg`, `bitcnt` and `tocnt`.
  - SHIFT: on each SCK rise, `shreg <= {shreg[14:0], sio}`. `bitcnt` increments and saturates at `FRAME_BITS+1`. `tocnt` resets on each SCK rise and otherwise increments.
  - SHIFT → DONE on CS rise.
  - SHIFT → ERR when `tocnt == IDLE_TIMEOUT`.
  - DONE: if `bitcnt == FRAME_BITS`, load `raw <= shreg` and pulse `frame_valid`. Otherwise pulse `frame_err` and leave `raw` unchanged. Always → IDLE.
  - ERR: pulse `frame_err`, then wait for `cs_n` high and → IDLE. No CS rise or SCK activity is processed until then.
- SCK rises while `cs_n` is high are ignored.
- A CS rise and an SCK rise in the same cycle: that edge is not shifted.
- `temp_c` is a combinational slice of `raw`. It truncates toward −∞ (for example −0.25 °C gives −1).
- `disp_byte` is combinational from `raw` and `sel_lsb` and may change at any cycle.

## Timing
- Reset values: `raw=0`, `temp_c=0`, `disp_byte=0`, `frame_valid=0`, `frame_err=0`. FSM = IDLE.
- Reset asserted mid-frame discards the partial frame. After release, the block waits for a fresh CS fall; a CS already low is ignored.
- Latency: `frame_valid` and the `raw` update occur 2 `clk` posedges after `cs_n` goes high (1 cycle to register, 1 cycle in DONE).
- `frame_valid` and `frame_err` are never high together. Each is high for exactly one cycle per frame.
- Minimum CS-high gap between frames: 2 `clk` cycles. A CS fall during DONE is missed.
- SIO must be stable at the `clk` posedge that sees SCK high. The sequencer's negedge SCK gives half a cycle of setup.

## Configuration
- `LM70_MINMAX_EN` defined:
  - `t_min` and `t_max` are registered.
  - Reset values: `t_min = +255` (9'h0FF), `t_max = −256` (9'h100).
  - On each `frame_valid`, both update with `temp_c` using signed compare, in the same cycle as `raw`.
- `LM70_MINMAX_EN` undefined: the ports and registers do not exist.

## Test plan
- Good frame: CS low, 16 SCK rises shifting 0x0C80, CS high → `raw=0x0C80`, `temp_c=25`, `frame_valid` pulses 2 cycles after CS high.
- Negative frame: shift 0xF380 → `temp_c=−25`. With `sel_lsb=1`, `disp_byte=0x80`; with `sel_lsb=0`, `disp_byte=0xF3`.
- Short frame: 8 SCK rises, then CS high → `frame_err` one pulse, `raw` keeps its prior value, no `frame_valid`.
- Timeout: CS low with SCK stopped for 64 cycles → `frame_err` at cycle 64. A later CS rise produces no second pulse.
- Reset at bit 9 of a frame, then a complete frame 0x4B00 → `raw=0x4B00`, `temp_c=150`.
- `LM70_MINMAX_EN`: frames 25 °C, −10 °C, 150 °C → `t_min=−10`, `t_max=150`.
